// File: rtl/coin_acceptor_if.sv
// Coin acceptor sensor/control/credit-pulse bundle.
// master drives the sensor and controls, slave is the acceptor.
interface coin_acceptor_if;
  logic coin_raw;
  logic hold;
  logic cancel;
  logic coin_in;
  logic coin_reject;
  logic busy;

  modport master (
    output coin_raw, hold, cancel,
    input  coin_in, coin_reject, busy
  );

  modport slave (
    input  coin_raw, hold, cancel,
    output coin_in, coin_reject, busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: sync, debounce, width classify, credit queue, paced coin_in.
// Optional COIN_ACCEPTOR_STATS_EN adds accepted_cnt / rejected_cnt outputs.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_W           = 3,
  parameter int SHORT_MAX       = 8,
  parameter int LONG_MAX        = 32,
  parameter int PULSE_GAP       = 2,
  parameter int CREDIT_W        = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  coin_acceptor_if.slave bus
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [7:0]     accepted_cnt,
  output logic [7:0]     rejected_cnt
`endif
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WID_W = $clog2(LONG_MAX + 2);
  localparam int GAP_W = $clog2(PULSE_GAP + 1);
  localparam int SUM_W = CREDIT_W + 2;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WID_W-1:0] WID_MIN  = WID_W'(MIN_W);
  localparam logic [WID_W-1:0] WID_SHT  = WID_W'(SHORT_MAX);
  localparam logic [WID_W-1:0] WID_LNG  = WID_W'(LONG_MAX);
  localparam logic [WID_W-1:0] WID_SAT  = WID_W'(LONG_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(PULSE_GAP);
  localparam logic [SUM_W-1:0] CRED_MAX = SUM_W'((1 << CREDIT_W) - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    CLASSIFY = 2'd2
  } state_t;

  state_t              state;
  logic                s1;
  logic                s2;
  logic                deb;
  logic [DEB_W-1:0]    deb_cnt;
  logic [WID_W-1:0]    width;
  logic [CREDIT_W-1:0] credit;
  logic [GAP_W-1:0]    gap;

  logic                bad;
  logic                valid;
  logic [1:0]          units;
  logic                emit;
  logic [SUM_W-1:0]    sum;
  logic                over;
  logic                rej_next;

  // Two-flop synchroniser then a stability filter on the raw sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1 <= bus.coin_raw;
      s2 <= s1;
      if (s2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Measure how long the debounced level stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      width <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (deb) begin
            state <= MEASURE;
            width <= WID_W'(1);
          end
        end
        MEASURE: begin
          if (!deb) begin
            state <= CLASSIFY;
          end else if (width != WID_SAT) begin
            width <= width + 1'b1;
          end
        end
        CLASSIFY: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Width classification and next-credit arithmetic.
  always_comb begin
    bad   = 1'b0;
    valid = 1'b0;
    units = 2'd0;
    if (state == CLASSIFY) begin
      if (width < WID_MIN || width > WID_LNG) begin
        bad = 1'b1;
      end else if (width <= WID_SHT) begin
        valid = 1'b1;
        units = 2'd1;
      end else begin
        valid = 1'b1;
        units = 2'd2;
      end
    end
    emit = (credit != '0) && (gap == '0) && !bus.hold && !bus.cancel;
    sum  = SUM_W'(credit) + SUM_W'(units) - SUM_W'(emit);
    over = sum > CRED_MAX;
    rej_next = bad || (over && !bus.cancel);
  end

  // Credit queue, pulse pacing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit          <= '0;
      gap             <= '0;
      bus.coin_in     <= 1'b0;
      bus.coin_reject <= 1'b0;
    end else begin
      if (bus.cancel) begin
        credit <= '0;
      end else if (over) begin
        credit <= CRED_MAX[CREDIT_W-1:0];
      end else begin
        credit <= sum[CREDIT_W-1:0];
      end
      if (emit) begin
        gap <= GAP_LD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      bus.coin_in     <= emit;
      bus.coin_reject <= rej_next;
    end
  end

  assign bus.busy = (state != IDLE) || (credit != '0);

`ifdef COIN_ACCEPTOR_STATS_EN
  // Running coin statistics; wrap naturally and ignore cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_cnt <= 8'd0;
      rejected_cnt <= 8'd0;
    end else begin
      if (valid) begin
        accepted_cnt <= accepted_cnt + 8'd1;
      end
      if (rej_next) begin
        rejected_cnt <= rejected_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_valid;
  assign unused_valid = valid;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a coin/reject scoreboard.
// Expected pulses are queued per test and popped as the DUT emits them.
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   test_id = 0;
  int   coin_q[$];
  int   rej_q[$];
  int   coin_times[$];
  int   t0;

  coin_acceptor_if bus();

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] accepted_cnt;
  logic [7:0] rejected_cnt;
`endif

  coin_acceptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    .accepted_cnt (accepted_cnt),
    .rejected_cnt (rejected_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each output pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.coin_in) begin
        coin_times.push_back(cyc);
        chk("coin_in_expected", int'(coin_q.size() > 0), 1);
        if (coin_q.size() > 0) chk("coin_in_test", coin_q.pop_front(), test_id);
      end
      if (bus.coin_reject) begin
        chk("reject_expected", int'(rej_q.size() > 0), 1);
        if (rej_q.size() > 0) chk("reject_test", rej_q.pop_front(), test_id);
      end
    end
  end

  task automatic coin(input int w);
    bus.coin_raw = 1'b1;
    repeat (w) @(negedge clk);
    bus.coin_raw = 1'b0;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_coin_q"}, coin_q.size(), 0);
    chk({tag, "_rej_q"}, rej_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.coin_raw = 1'b0;
    bus.hold = 1'b0;
    bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coin_in", bus.coin_in, 0);
    chk("rst_reject", bus.coin_reject, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short coin: one unit, exact first-pulse latency
    test_id = 1;
    coin_times.delete();
    coin_q.push_back(1);
    t0 = cyc;
    coin(6);
    repeat (3) @(negedge clk);
    chk("short_busy_measuring", bus.busy, 1);
    repeat (30) @(negedge clk);
    drained("short");
    chk("short_busy_done", bus.busy, 0);
    chk("short_pulses", coin_times.size(), 1);
    if (coin_times.size() > 0)
      chk("short_latency", coin_times[0] - t0, 15);

    // Long coin: two units spaced PULSE_GAP+1
    test_id = 2;
    coin_times.delete();
    coin_q.push_back(2);
    coin_q.push_back(2);
    coin(20);
    repeat (40) @(negedge clk);
    drained("long");
    chk("long_pulses", coin_times.size(), 2);
    if (coin_times.size() == 2)
      chk("long_spacing", coin_times[1] - coin_times[0], 3);
    chk("long_busy_done", bus.busy, 0);

    // Glitch is filtered out
    test_id = 3;
    coin(2);
    repeat (8) @(negedge clk);
    chk("glitch_busy", bus.busy, 0);
    repeat (20) @(negedge clk);
    drained("glitch");

    // Stuck sensor: rejected, no credit
    test_id = 4;
    rej_q.push_back(4);
    coin(40);
    repeat (30) @(negedge clk);
    drained("stuck");
    chk("stuck_busy", bus.busy, 0);

    // Saturation under hold: 8 long coins, last one overflows
    test_id = 5;
    bus.hold = 1'b1;
    rej_q.push_back(5);
    for (int i = 0; i < 8; i++) begin
      coin(20);
      repeat (15) @(negedge clk);
    end
    chk("sat_rej_seen", rej_q.size(), 0);
    chk("sat_busy_held", bus.busy, 1);
    coin_times.delete();
    for (int i = 0; i < 15; i++) coin_q.push_back(5);
    bus.hold = 1'b0;
    repeat (60) @(negedge clk);
    drained("sat");
    chk("sat_pulses", coin_times.size(), 15);
    chk("sat_busy_done", bus.busy, 0);

    // Cancel on the cycle an emit would occur
    test_id = 6;
    bus.hold = 1'b1;
    coin(20);
    repeat (20) @(negedge clk);
    chk("cancel_busy_before", bus.busy, 1);
    bus.hold = 1'b0;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_no_coin", bus.coin_in, 0);
    chk("cancel_busy_after", bus.busy, 0);
    repeat (20) @(negedge clk);
    drained("cancel");

    // Coin measured across a cancel still credits; older credit is lost
    test_id = 7;
    bus.hold = 1'b1;
    coin(6);
    repeat (20) @(negedge clk);
    bus.coin_raw = 1'b1;
    repeat (12) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    repeat (7) @(negedge clk);
    bus.coin_raw = 1'b0;
    repeat (20) @(negedge clk);
    chk("across_busy_held", bus.busy, 1);
    coin_times.delete();
    coin_q.push_back(7);
    coin_q.push_back(7);
    bus.hold = 1'b0;
    repeat (30) @(negedge clk);
    drained("across");
    chk("across_pulses", coin_times.size(), 2);

    // Reset mid-emission clears everything immediately
    test_id = 8;
    bus.hold = 1'b1;
    coin(20);
    repeat (20) @(negedge clk);
    coin_times.delete();
    coin_q.push_back(8);
    bus.hold = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_coin_in", bus.coin_in, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_coin_in", bus.coin_in, 0);
    chk("mid_rst_reject", bus.coin_reject, 0);
    chk("mid_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    drained("post_rst");
    chk("post_rst_pulses", coin_times.size(), 1);
    chk("post_rst_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that sits directly upstream of the vending machine FSM and produces its `coin_in` credit pulses. It synchronises and debounces a raw coin-sensor line and classifies each coin by its debounced pulse width. It queues the resulting credit units and emits them as single-cycle, evenly spaced `coin_in` pulses. Invalid or stuck coins are flagged on `coin_reject` instead of producing credit.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before the debounced level changes.
- `MIN_W`, 3: minimum debounced high width, in cycles, for a valid coin.
- `SHORT_MAX`, 8: widths `MIN_W..SHORT_MAX` are worth 1 unit.
- `LONG_MAX`, 32: widths `SHORT_MAX+1..LONG_MAX` are worth 2 units; wider is rejected.
- `PULSE_GAP`, 2: idle cycles forced between consecutive `coin_in` pulses.
- `CREDIT_W`, 4: pending-credit counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coin_raw` in 1: asynchronous raw sensor; high while a coin passes.
- `hold` in 1: while high, emission is paused; measurement continues.
- `cancel` in 1: synchronous; discards all pending credit.
- `coin_in` out 1: one-cycle pulse per credit unit, to the vending machine.
- `coin_reject` out 1: one-cycle pulse when a coin is rejected or credit overflows.
- `busy` out 1: high while a coin is being measured or credit is nonzero.

## Operation
- Input path:
  - 2-FF synchroniser on `coin_raw`.
  - Debouncer: the debounced level `deb` takes the synchronised value after it differs from `deb` for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle restarts the count.
- Measurement FSM, states IDLE, MEASURE, CLASSIFY:
  - IDLE→MEASURE on `deb` rising; width counter loads 1.
  - In MEASURE, the counter increments each cycle `deb` is high and saturates at `LONG_MAX+1`.
  - MEASURE→CLASSIFY on `deb` falling.
  - CLASSIFY lasts one cycle, then returns to IDLE.
- Classification, performed in CLASSIFY:
  - width < `MIN_W` or > `LONG_MAX`: `coin_reject`, 0 units.
  - width in `MIN_W..SHORT_MAX`: 1 unit.
  - width in `SHORT_MAX+1..LONG_MAX`: 2 units.
- Credit counter:
  - Next value = credit + units − (emit ? 1 : 0).
  - If the sum exceeds 2^`CREDIT_W`−1, credit saturates at the maximum, `coin_reject` pulses, and the excess is lost.
- Emitter:
  - `coin_in` pulses when credit > 0, the gap counter = 0, `hold` = 0 and `cancel` = 0.
  - The same edge decrements credit and loads the gap counter with `PULSE_GAP`.
  - The gap counter decrements to 0 independently of `hold`.
- `cancel`:
  - Credit is cleared to 0 and overrides a same-cycle add and emit.
  - No `coin_in` pulse is produced in that cycle.
  - Measurement in progress is unaffected; its coin credits normally afterwards.
- `busy` = (state ≠ IDLE) or (credit ≠ 0).

## Timing
- Reset values:
  - Outputs: `coin_in` = 0, `coin_reject` = 0, `busy` = 0.
  - Internal state: FSM IDLE, credit 0, gap 0, sync/debounce flops 0.
- Reset takes effect immediately, including mid-measurement or mid-emission. No partial credit survives.
- Latency, `coin_raw` rise to `deb` rise: 2 sync + `DEBOUNCE_CYCLES` cycles. The fall path has the same latency.
- Latency, `deb` fall to CLASSIFY: 1 cycle. The credit update is visible on the following edge.
- The first `coin_in` is asserted the cycle after credit becomes nonzero, when gap = 0 and `hold` = 0.
- Pulse spacing: `coin_in` rising edges are exactly `PULSE_GAP`+1 cycles apart while credit remains and `hold` = 0.
- `coin_reject` and `coin_in` may assert in the same cycle.

## Configuration
- `COIN_ACCEPTOR_STATS_EN`:
  - Defined: adds output `accepted_cnt` [7:0], which increments per valid coin (not per unit). Adds output `rejected_cnt` [7:0], which increments per `coin_reject` pulse. Both wrap 255→0, reset to 0 and are not cleared by `cancel`.
  - Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset: assert `rst_n` = 0 mid-emission with credit = 2 → `coin_in`, `coin_reject`, `busy` are 0 immediately. After release, no further `coin_in` occurs.
- Short coin: `coin_raw` high 6 clean cycles → exactly one `coin_in` pulse, `busy` returns to 0 after it, no `coin_reject`.
- Long coin: `coin_raw` high 20 cycles → two `coin_in` pulses with rising edges 3 cycles apart.
- Noise and stuck sensor:
  - 2-cycle glitch → no state change, no outputs.
  - `coin_raw` high 40 cycles → one `coin_reject`, zero `coin_in`.
- Saturation with `hold` = 1: insert eight long coins → credit reaches 15, last coin gives one `coin_reject`. Release `hold` → exactly 15 `coin_in` pulses.
- Cancel: with credit = 2, assert `cancel` on the cycle an emit would occur → no `coin_in` that cycle or after, `busy` = 0 next cycle. A coin measured across the cancel still yields its units.
